// File: rtl/rr_multi_priority_finder_pkg.sv
// rtl/rr_multi_priority_finder_pkg.sv - shared types and helpers for the multi-grant priority finder
// Contents:
//   idx_width(w) : index width for a w-entry vector, never below 1
//   rr_mode_e    : search mode (fixed start at 0, or rotating pointer)
//   grant_ch_t   : one grant channel {valid, index}; index is wide enough for any supported WIDTH
package priority_pkg;

  localparam int IDX_MAX_W = 16;

  function automatic int idx_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

  typedef enum logic {
    RR_FIXED  = 1'b0,
    RR_ROTATE = 1'b1
  } rr_mode_e;

  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] index;
  } grant_ch_t;

endpackage

// File: rtl/rr_multi_priority_finder_if.sv
// rtl/rr_multi_priority_finder_if.sv - request/grant bundle between requesters, consumer and finder
// Signals:
//   flush       : drop the grant stage, no capture this cycle
//   req         : request bits
//   req_accept  : requests captured this cycle (combinational)
//   out_ready   : consumer takes the grant stage
//   out_valid   : grant stage holds at least one grant
//   grant_valid : per-channel valid, thermometer from channel 0
//   grant_index : per-channel granted index
//   ptr         : current search start
// Modports: master = requester/consumer side, slave = finder side.
interface rr_multi_priority_finder_if #(
  parameter int WIDTH     = 16,
  parameter int GRANT_NUM = 2
) ();
  import priority_pkg::*;

  localparam int IW = idx_width(WIDTH);

  logic                         flush;
  logic [WIDTH-1:0]             req;
  logic [WIDTH-1:0]             req_accept;
  logic                         out_ready;
  logic                         out_valid;
  logic [GRANT_NUM-1:0]         grant_valid;
  logic [GRANT_NUM-1:0][IW-1:0] grant_index;
  logic [IW-1:0]                ptr;

  modport master (
    output flush, req, out_ready,
    input  req_accept, out_valid, grant_valid, grant_index, ptr
  );

  modport slave (
    input  flush, req, out_ready,
    output req_accept, out_valid, grant_valid, grant_index, ptr
  );

endinterface

// File: rtl/rr_multi_priority_finder_rotated_first_finder.sv
// rtl/rr_multi_priority_finder_rotated_first_finder.sv - first set bit at or after a start index, wrapping
// Ports:
//   mask  : candidate bits
//   start : index where the search begins
//   index : first set bit in order start, start+1, ... (mod WIDTH); 0 when none
//   found : at least one bit of mask is set
module rotated_first_finder
  import priority_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]            mask,
  input  logic [idx_width(WIDTH)-1:0] start,
  output logic [idx_width(WIDTH)-1:0] index,
  output logic                        found
);
  localparam int IW = idx_width(WIDTH);

  logic [IW-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  // WIDTH is a power of two, so IW-bit overflow of start+offset is exactly mod WIDTH.
  always_comb begin
    index = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      pos = start + IW'(i);
      if (mask[pos]) begin
        index = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_multi_priority_finder.sv
// rtl/rr_multi_priority_finder.sv - picks up to GRANT_NUM requests per cycle into a registered grant stage
// Ports:
//   clk : clock
//   rst : synchronous reset, active high
//   bus : slave side of rr_multi_priority_finder_if (req/accept, grant stage, ptr)
module rr_multi_priority_finder
  import priority_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int GRANT_NUM   = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  rr_multi_priority_finder_if.slave bus
);
  localparam int       IW   = idx_width(WIDTH);
  localparam rr_mode_e MODE = (ROUND_ROBIN != 0) ? RR_ROTATE : RR_FIXED;

  logic [IW-1:0]                ptr_q, ptr_d;
  logic                         out_valid_q, out_valid_d;
  logic [GRANT_NUM-1:0]         grant_valid_q, grant_valid_d;
  logic [GRANT_NUM-1:0][IW-1:0] grant_index_q, grant_index_d;

  logic [IW-1:0]                   search_start;
  logic [GRANT_NUM-1:0][WIDTH-1:0] stage_mask;
  logic [GRANT_NUM-1:0]            found;
  logic [GRANT_NUM-1:0][IW-1:0]    found_index;
  logic [WIDTH-1:0]                chosen;
  logic [IW-1:0]                   last_index;
  logic                            load;
  logic                            capture;

  assign search_start  = (MODE == RR_ROTATE) ? ptr_q : '0;
  assign stage_mask[0] = bus.req;

  // Every stage searches from the same start; removing each earlier winner
  // from the mask makes stage k land on the k-th set bit in search order.
  for (genvar k = 0; k < GRANT_NUM; k++) begin : g_stage
    rotated_first_finder #(
      .WIDTH (WIDTH)
    ) u_finder (
      .mask  (stage_mask[k]),
      .start (search_start),
      .index (found_index[k]),
      .found (found[k])
    );

    if (k < GRANT_NUM - 1) begin : g_mask
      assign stage_mask[k+1] = found[k]
                             ? (stage_mask[k] & ~(WIDTH'(1) << found_index[k]))
                             : stage_mask[k];
    end
  end

  always_comb begin
    chosen     = '0;
    last_index = '0;
    for (int k = 0; k < GRANT_NUM; k++) begin
      if (found[k]) begin
        chosen[found_index[k]] = 1'b1;
        last_index             = found_index[k];
      end
    end
  end

  // An empty stage always loads; out_ready only matters while a grant is held.
  assign load           = ~out_valid_q | bus.out_ready;
  assign capture        = load & ~bus.flush & ~rst;
  assign bus.req_accept = capture ? chosen : '0;

  always_comb begin
    ptr_d         = ptr_q;
    out_valid_d   = out_valid_q;
    grant_valid_d = grant_valid_q;
    grant_index_d = grant_index_q;
    if (bus.flush) begin
      out_valid_d   = 1'b0;
      grant_valid_d = '0;
      grant_index_d = '0;
    end else if (load) begin
      out_valid_d   = |found;
      grant_valid_d = found;
      for (int k = 0; k < GRANT_NUM; k++) begin
        grant_index_d[k] = found[k] ? found_index[k] : '0;
      end
      if ((MODE == RR_ROTATE) && (|found)) begin
        ptr_d = last_index + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      out_valid_q   <= 1'b0;
      grant_valid_q <= '0;
      grant_index_q <= '0;
    end else begin
      ptr_q         <= ptr_d;
      out_valid_q   <= out_valid_d;
      grant_valid_q <= grant_valid_d;
      grant_index_q <= grant_index_d;
    end
  end

  assign bus.ptr         = ptr_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_index = grant_index_q;

endmodule

// File: tb/tb_rr_multi_priority_finder.sv
// tb/tb_rr_multi_priority_finder.sv - self-checking bench for rr_multi_priority_finder (round-robin and fixed instances)
module tb_rr_multi_priority_finder;
  import priority_pkg::*;

  localparam int W  = 8;
  localparam int G  = 2;
  localparam int IW = idx_width(W);

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rr_multi_priority_finder_if #(.WIDTH(W), .GRANT_NUM(G)) bus_rr ();
  rr_multi_priority_finder_if #(.WIDTH(W), .GRANT_NUM(G)) bus_fx ();

  rr_multi_priority_finder #(.WIDTH(W), .GRANT_NUM(G), .ROUND_ROBIN(1)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_rr.slave)
  );

  rr_multi_priority_finder #(.WIDTH(W), .GRANT_NUM(G), .ROUND_ROBIN(0)) dut_fx (
    .clk (clk),
    .rst (rst),
    .bus (bus_fx.slave)
  );

  // Reference state: index 0 is the round-robin instance, 1 the fixed one.
  bit           m_rr [2] = '{1'b1, 1'b0};
  int           m_ptr[2];
  bit           m_ov [2];
  grant_ch_t    m_g  [2][G];
  grant_ch_t    pk   [G];
  logic [W-1:0] obs_acc[2];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Walk the circular order from start and take the first G requesters.
  function automatic void pick(input int start, input logic [W-1:0] r);
    int n;
    int i;
    n = 0;
    for (int k = 0; k < G; k++) pk[k] = '{valid: 1'b0, index: '0};
    for (int off = 0; off < W; off++) begin
      i = (start + off) % W;
      if (r[i] && n < G) begin
        pk[n] = '{valid: 1'b1, index: IDX_MAX_W'(i)};
        n++;
      end
    end
  endfunction

  task automatic cyc(input logic [W-1:0] r, input logic rdy, input logic fl, input logic rs);
    grant_ch_t    nxt[2][G];
    logic [W-1:0] acc;
    logic [G-1:0] gv;
    bit           any;
    int           last;
    rst              = rs;
    bus_rr.req       = r;
    bus_fx.req       = r;
    bus_rr.out_ready = rdy;
    bus_fx.out_ready = rdy;
    bus_rr.flush     = fl;
    bus_fx.flush     = fl;
    #1;
    for (int d = 0; d < 2; d++) begin
      pick(m_rr[d] ? m_ptr[d] : 0, r);
      acc = '0;
      for (int k = 0; k < G; k++) begin
        nxt[d][k] = pk[k];
        if (pk[k].valid) acc[int'(pk[k].index)] = 1'b1;
      end
      if (!(!m_ov[d] || rdy) || fl || rs) acc = '0;
      obs_acc[d] = (d == 0) ? bus_rr.req_accept : bus_fx.req_accept;
      chk($sformatf("accept%0d", d), 32'(obs_acc[d]), 32'(acc));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rs) begin
        m_ptr[d] = 0;
        m_ov[d]  = 1'b0;
        for (int k = 0; k < G; k++) m_g[d][k] = '{valid: 1'b0, index: '0};
      end else if (fl) begin
        m_ov[d] = 1'b0;
        for (int k = 0; k < G; k++) m_g[d][k] = '{valid: 1'b0, index: '0};
      end else if (!m_ov[d] || rdy) begin
        any  = 1'b0;
        last = 0;
        for (int k = 0; k < G; k++) begin
          m_g[d][k] = nxt[d][k];
          if (nxt[d][k].valid) begin
            any  = 1'b1;
            last = int'(nxt[d][k].index);
          end
        end
        m_ov[d] = any;
        if (m_rr[d] && any) m_ptr[d] = (last + 1) % W;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      gv = '0;
      for (int k = 0; k < G; k++) gv[k] = m_g[d][k].valid;
      chk($sformatf("out_valid%0d", d),
          32'((d == 0) ? bus_rr.out_valid : bus_fx.out_valid), 32'(m_ov[d]));
      chk($sformatf("ptr%0d", d),
          32'((d == 0) ? bus_rr.ptr : bus_fx.ptr), 32'(m_ptr[d]));
      chk($sformatf("grant_valid%0d", d),
          32'((d == 0) ? bus_rr.grant_valid : bus_fx.grant_valid), 32'(gv));
      for (int k = 0; k < G; k++) begin
        chk($sformatf("grant_index%0d_ch%0d", d, k),
            32'((d == 0) ? bus_rr.grant_index[k] : bus_fx.grant_index[k]),
            32'(m_g[d][k].index));
      end
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus_rr.req       = '0;
    bus_fx.req       = '0;
    bus_rr.out_ready = 1'b0;
    bus_fx.out_ready = 1'b0;
    bus_rr.flush     = 1'b0;
    bus_fx.flush     = 1'b0;

    // Reset held two cycles with every request raised.
    cyc(8'hFF, 1'b0, 1'b0, 1'b1);
    chk("t1_accept", 32'(obs_acc[0]), 32'h0);
    chk("t1_out_valid", 32'(bus_rr.out_valid), 32'h0);
    cyc(8'hFF, 1'b1, 1'b0, 1'b1);
    chk("t1_accept_b", 32'(obs_acc[0]), 32'h0);
    chk("t1_ptr", 32'(bus_rr.ptr), 32'h0);
    chk("t1_grant_valid", 32'(bus_rr.grant_valid), 32'h0);

    // Basic capture from ptr 0.
    cyc(8'b1010_0110, 1'b1, 1'b0, 1'b0);
    chk("t2_accept", 32'(obs_acc[0]), 32'(8'b0000_0110));
    chk("t2_grant_valid", 32'(bus_rr.grant_valid), 32'(2'b11));
    chk("t2_ch0", 32'(bus_rr.grant_index[0]), 32'd1);
    chk("t2_ch1", 32'(bus_rr.grant_index[1]), 32'd2);
    chk("t2_ptr", 32'(bus_rr.ptr), 32'd3);

    // Move ptr to 6, then a search that wraps 7 -> 0.
    cyc(8'b0010_0000, 1'b1, 1'b0, 1'b0);
    chk("t3_setup_ptr", 32'(bus_rr.ptr), 32'd6);
    cyc(8'b0100_0001, 1'b1, 1'b0, 1'b0);
    chk("t3_accept", 32'(obs_acc[0]), 32'(8'b0100_0001));
    chk("t3_ch0", 32'(bus_rr.grant_index[0]), 32'd6);
    chk("t3_ch1", 32'(bus_rr.grant_index[1]), 32'd0);
    chk("t3_ptr", 32'(bus_rr.ptr), 32'd1);

    // Backpressure: grant stage and ptr frozen, nothing accepted.
    repeat (3) begin
      cyc(8'hFF, 1'b0, 1'b0, 1'b0);
      chk("t4_accept", 32'(obs_acc[0]), 32'h0);
      chk("t4_out_valid", 32'(bus_rr.out_valid), 32'h1);
      chk("t4_ch0", 32'(bus_rr.grant_index[0]), 32'd6);
      chk("t4_ptr", 32'(bus_rr.ptr), 32'd1);
    end
    cyc(8'hFF, 1'b1, 1'b0, 1'b0);
    chk("t4_release_accept", 32'(obs_acc[0]), 32'(8'b0000_0110));
    chk("t4_release_ptr", 32'(bus_rr.ptr), 32'd3);

    // Partial grant, then an empty load.
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    cyc(8'b0001_0000, 1'b1, 1'b0, 1'b0);
    chk("t5_grant_valid", 32'(bus_rr.grant_valid), 32'(2'b01));
    chk("t5_ch0", 32'(bus_rr.grant_index[0]), 32'd4);
    chk("t5_ch1", 32'(bus_rr.grant_index[1]), 32'd0);
    chk("t5_ptr", 32'(bus_rr.ptr), 32'd5);
    cyc(8'h00, 1'b1, 1'b0, 1'b0);
    chk("t5_empty_out_valid", 32'(bus_rr.out_valid), 32'h0);
    chk("t5_empty_ptr", 32'(bus_rr.ptr), 32'd5);

    // Flush drops a held grant even with out_ready high.
    cyc(8'b0100_0000, 1'b1, 1'b0, 1'b0);
    chk("t6_setup_ptr", 32'(bus_rr.ptr), 32'd7);
    cyc(8'h03, 1'b1, 1'b1, 1'b0);
    chk("t6_flush_accept", 32'(obs_acc[0]), 32'h0);
    chk("t6_flush_out_valid", 32'(bus_rr.out_valid), 32'h0);
    chk("t6_flush_ptr", 32'(bus_rr.ptr), 32'd7);
    chk("t6_flush_grant_valid", 32'(bus_rr.grant_valid), 32'h0);

    // Fixed priority repeats the same pick.
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    repeat (2) begin
      cyc(8'b1010_0110, 1'b1, 1'b0, 1'b0);
      chk("t6_fixed_accept", 32'(obs_acc[1]), 32'(8'b0000_0110));
      chk("t6_fixed_ch0", 32'(bus_fx.grant_index[0]), 32'd1);
      chk("t6_fixed_ch1", 32'(bus_fx.grant_index[1]), 32'd2);
      chk("t6_fixed_ptr", 32'(bus_fx.ptr), 32'd0);
    end

    // Random traffic against the reference.
    for (int n = 0; n < 400; n++) begin
      cyc(W'($urandom), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
